// File: rtl/enose_pkg.sv
// rtl/enose_pkg.sv - shared state encoding and result-word layout for the inference scheduler
package enose_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_COLLECT,
    ST_GAP,
    ST_ABORT
  } sched_state_t;

  localparam int RES_SEQ_LSB   = 16;
  localparam int RES_SEQ_W     = 16;
  localparam int RES_CLASS_LSB = 14;
  localparam int RES_CLASS_W   = 2;
  localparam int RES_CNT_LSB   = 0;
  localparam int RES_CNT_W     = 14;

  localparam logic [RES_CNT_W-1:0] WIN_COUNT_SAT = 14'h3FFF;

  // Win counts above the 14-bit field clamp to all-ones rather than wrapping.
  function automatic logic [31:0] pack_result(input logic [15:0] seq,
                                              input logic [1:0]  cls,
                                              input logic [15:0] cnt);
    logic [31:0]          word;
    logic [RES_CNT_W-1:0] sat;
    sat  = (cnt > {2'b00, WIN_COUNT_SAT}) ? WIN_COUNT_SAT : cnt[RES_CNT_W-1:0];
    word = '0;
    word[RES_SEQ_LSB +: RES_SEQ_W]     = seq;
    word[RES_CLASS_LSB +: RES_CLASS_W] = cls;
    word[RES_CNT_LSB +: RES_CNT_W]     = sat;
    return word;
  endfunction

endpackage

// File: rtl/enose_res_fifo.sv
// rtl/enose_res_fifo.sv - first-word-fall-through result FIFO with occupancy count
module enose_res_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int AW = CNT_W - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  // Head is forced to zero when empty so the outputs read 0 out of reset.
  assign rdata   = valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/enose_infer_sched.sv
// rtl/enose_infer_sched.sv - autonomous inference-window scheduler; ENOSE_SCHED_WATCHDOG_EN adds the run watchdog
module enose_infer_sched
  import enose_pkg::*;
#(
  parameter int RES_DEPTH = 8,
  parameter int WLEN_W    = 6
) (
  input  logic              s00_axi_aclk,
  input  logic              s00_axi_aresetn,
  input  logic              cmd_go,
  input  logic              cmd_abort,
  input  logic [WLEN_W-1:0] cfg_window_len,
  input  logic [15:0]       cfg_num_windows,
  input  logic [15:0]       cfg_gap_cycles,
  input  logic [31:0]       cfg_timeout,
  output logic              core_start,
  output logic              core_reset,
  output logic [WLEN_W-1:0] core_window_len,
  input  logic              core_done,
  input  logic [1:0]        core_class,
  input  logic [15:0]       core_win_count,
  input  logic [31:0]       core_latency,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [31:0]       res_latency,
  output logic              busy,
  output logic              sched_done,
  output logic [15:0]       windows_done,
  output logic              err_cfg,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(RES_DEPTH) + 1;

  sched_state_t state, state_d;
  logic [15:0]  num_q, gap_q, gap_cnt, seq;
  logic [1:0]   cap_class;
  logic [15:0]  cap_count;
  logic [31:0]  cap_lat;
  logic         start_d, reset_d, done_d, push, go_ok, go_bad, capture, timeout_hit, last_win;
  logic         fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic [63:0]  fifo_rdata;

  assign busy     = (state != ST_IDLE);
  assign push     = (state == ST_COLLECT);
  assign last_win = (num_q != 16'd0) && (windows_done + 16'd1 == num_q);

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) state <= ST_IDLE;
    else                  state <= state_d;
  end

  // Abort overrides everything, so a core_done arriving with it is never captured.
  always_comb begin
    state_d = state;
    start_d = 1'b0;
    reset_d = 1'b0;
    done_d  = 1'b0;
    go_ok   = 1'b0;
    go_bad  = 1'b0;
    capture = 1'b0;
    if (cmd_abort) begin
      state_d = ST_ABORT;
      reset_d = 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (cmd_go) begin
          if (cfg_window_len == '0) go_bad = 1'b1;
          else begin
            go_ok   = 1'b1;
            state_d = ST_START;
          end
        end
        ST_START: if (!fifo_full) begin
          start_d = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: if (core_done) begin
          capture = 1'b1;
          state_d = ST_COLLECT;
        end else if (timeout_hit) begin
          reset_d = 1'b1;
          state_d = ST_ABORT;
        end
        ST_COLLECT: if (last_win) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (gap_q == 16'd0) state_d = ST_START;
        else                         state_d = ST_GAP;
        ST_GAP:   if (gap_cnt == 16'd1) state_d = ST_START;
        ST_ABORT: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      core_start      <= 1'b0;
      core_reset      <= 1'b0;
      sched_done      <= 1'b0;
      core_window_len <= '0;
      num_q           <= '0;
      gap_q           <= '0;
      gap_cnt         <= '0;
      seq             <= '0;
      windows_done    <= '0;
      err_cfg         <= 1'b0;
      cap_class       <= '0;
      cap_count       <= '0;
      cap_lat         <= '0;
    end else begin
      core_start <= start_d;
      core_reset <= reset_d;
      sched_done <= done_d;
      if (go_ok) begin
        core_window_len <= cfg_window_len;
        num_q           <= cfg_num_windows;
        gap_q           <= cfg_gap_cycles;
        seq             <= '0;
        windows_done    <= '0;
        err_cfg         <= 1'b0;
      end else if (go_bad) begin
        err_cfg <= 1'b1;
      end
      if (capture) begin
        cap_class <= core_class;
        cap_count <= core_win_count;
        cap_lat   <= core_latency;
      end
      if (push) begin
        seq <= seq + 16'd1;
        if (windows_done != 16'hFFFF) windows_done <= windows_done + 16'd1;
      end
      if (state == ST_COLLECT)  gap_cnt <= gap_q;
      else if (state == ST_GAP) gap_cnt <= gap_cnt - 16'd1;
    end
  end

`ifdef ENOSE_SCHED_WATCHDOG_EN
  logic [31:0] wd_cnt;
  logic [31:0] wd_next;

  // wd_next is the 1-based index of the current RUN cycle.
  assign wd_next     = wd_cnt + 32'd1;
  assign timeout_hit = (cfg_timeout != 32'd0) && (wd_next == cfg_timeout);

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (start_d)              wd_cnt <= '0;
      else if (state == ST_RUN) wd_cnt <= wd_next;
      if (go_ok) err_timeout <= 1'b0;
      else if (state == ST_RUN && !cmd_abort && !core_done && timeout_hit) err_timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^cfg_timeout;
  assign timeout_hit    = 1'b0;
  assign err_timeout    = 1'b0;
`endif

  enose_res_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (64),
    .CNT_W (CNT_W)
  ) u_res_fifo (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .push  (push),
    .wdata ({pack_result(seq, cap_class, cap_count), cap_lat}),
    .pop   (res_ready),
    .rdata (fifo_rdata),
    .valid (res_valid),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign res_data    = fifo_rdata[63:32];
  assign res_latency = fifo_rdata[31:0];

endmodule
